// File: rtl/adder_subtractor.sv
// Registered two's-complement adder/subtractor with carry, overflow, zero and
// negative flags; one-cycle latency, result held while no new operands arrive.
module adder_subtractor #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] answer,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_carry;
  logic             w_overflow;
  logic             w_zero;
  logic             w_negative;

  logic [WIDTH-1:0] r_answer;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_zero;
  logic             r_negative;
  logic             r_out_valid;

  // Subtraction as A + ~B + 1: invert B under s and feed s in as carry-in
  assign w_b_eff    = b ^ {WIDTH{s}};
  assign w_carry[0] = s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign w_sum[i]       = a[i] ^ w_b_eff[i] ^ w_carry[i];
    assign w_carry[i + 1] = (a[i] & w_b_eff[i]) | (w_carry[i] & (a[i] ^ w_b_eff[i]));
  end

  assign w_overflow = w_carry[WIDTH] ^ w_carry[WIDTH-1];
  assign w_zero     = (w_sum == '0);
  assign w_negative = w_sum[WIDTH-1];

  // Reset value keeps zero consistent with answer = 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_answer    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b1;
      r_negative  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_answer    <= w_sum;
        r_carry_out <= w_carry[WIDTH];
        r_overflow  <= w_overflow;
        r_zero      <= w_zero;
        r_negative  <= w_negative;
      end
    end
  end

  assign answer    = r_answer;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign negative  = r_negative;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_adder_subtractor.sv
// Directed bench for adder_subtractor at WIDTH = 6 with hand-computed results.
module tb_adder_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] a;
  logic [5:0] b;
  logic       s;
  logic [5:0] answer;
  logic       carry_out;
  logic       overflow;
  logic       zero;
  logic       negative;
  logic       out_valid;

  int checks   = 0;
  int failures = 0;

  adder_subtractor #(.WIDTH(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .s         (s),
    .answer    (answer),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [5:0] e_ans, input logic e_c,
                         input logic e_v, input logic e_z, input logic e_n, input logic e_ov);
    chk({tag, ".answer"},    32'(answer),    32'(e_ans));
    chk({tag, ".carry_out"}, 32'(carry_out), 32'(e_c));
    chk({tag, ".overflow"},  32'(overflow),  32'(e_v));
    chk({tag, ".zero"},      32'(zero),      32'(e_z));
    chk({tag, ".negative"},  32'(negative),  32'(e_n));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
  endtask

  task automatic drive(input logic v, input logic [5:0] ta, input logic [5:0] tb, input logic ts);
    in_valid = v;
    a        = ta;
    b        = tb;
    s        = ts;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    s        = 1'b0;
    #12;
    chk_all("reset", 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("idle", 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back valid operations, one per cycle
    drive(1'b1, 6'd3, 6'd35, 1'b0);
    chk_all("add_3_35", 6'd38, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 6'd3, 6'd35, 1'b1);
    chk_all("sub_3_35", 6'd32, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 6'd35, 6'd3, 1'b1);
    chk_all("sub_35_3", 6'd32, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 6'd63, 6'd1, 1'b0);
    chk_all("add_63_1", 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 6'd31, 6'd1, 1'b0);
    chk_all("add_31_1", 6'd32, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 6'd32, 6'd1, 1'b1);
    chk_all("sub_32_1", 6'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 6'd32, 6'd32, 1'b0);
    chk_all("add_32_32", 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 6'd0, 6'd0, 1'b1);
    chk_all("sub_0_0", 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 6'd10, 6'd20, 1'b0);
    chk_all("add_10_20", 6'd30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // No new operands: result and flags hold, out_valid drops
    drive(1'b0, 6'd63, 6'd63, 1'b1);
    chk_all("hold1", 6'd30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 6'd1, 6'd2, 1'b0);
    chk_all("hold2", 6'd30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    drive(1'b1, 6'd31, 6'd1, 1'b0);
    chk_all("pre_reset", 6'd32, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset between edges clears outputs without a clock
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 6'd5, 6'd5, 1'b1);
    chk_all("sub_5_5", 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 6'd0, 6'd0, 1'b0);
    chk_all("final_idle", 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
